// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
package pc_seq_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          JUMP_FIELD_W = 26;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: level request with a one-cycle ack carrying the data.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Next fetch address for a consumed instruction: jump, taken branch or sequential.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]       i_pc,
  input  logic                    i_branch,
  input  logic [15:0]             i_branch_off,
  input  logic                    i_jump,
  input  logic [JUMP_FIELD_W-1:0] i_jump_tgt,
  output logic [ADDR_W-1:0]       o_next_pc
);

  function automatic logic signed [ADDR_W-1:0] sext_off(input logic [15:0] off);
    return {{(ADDR_W-16){off[15]}}, off};
  endfunction

  logic [ADDR_W-1:0]        w_pc1;
  logic signed [ADDR_W-1:0] w_off_sext;

  assign w_pc1      = i_pc + ADDR_W'(1);
  assign w_off_sext = sext_off(i_branch_off);

  // Jump keeps the upper bits of pc+1, not of the jump's own PC.
  always_comb begin
    o_next_pc = w_pc1;
    if (i_jump) begin
      o_next_pc = {w_pc1[ADDR_W-1:JUMP_FIELD_W], i_jump_tgt};
    end else if (i_branch) begin
      o_next_pc = w_pc1 + $unsigned(w_off_sext);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, runs imem fetches and hands instructions to decode.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    branch_i,
  input  logic [15:0]             branch_off_i,
  input  logic                    jump_i,
  input  logic [JUMP_FIELD_W-1:0] jump_tgt_i,
  input  logic                    halt_i,
  input  logic                    flush_i,
  input  logic [ADDR_W-1:0]       flush_pc_i,
  pc_sequencer_if.master          imem,
  output logic [31:0]             instr_o,
  output logic                    instr_valid_o,
  output logic [ADDR_W-1:0]       pc_o,
  output logic                    halted_o
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_FETCH   = ST_FETCH;
  localparam logic [1:0] S_DELIVER = ST_DELIVER;
  localparam logic [1:0] S_HALTED  = ST_HALTED;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_new_pc;
  logic              r_drop;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] w_next_pc;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .i_pc         (r_pc),
    .i_branch     (branch_i),
    .i_branch_off (branch_off_i),
    .i_jump       (jump_i),
    .i_jump_tgt   (jump_tgt_i),
    .o_next_pc    (w_next_pc)
  );

  assign imem.imem_req  = (r_state == S_FETCH);
  assign imem.imem_addr = r_fetch_pc;
  assign instr_o        = r_instr;
  assign instr_valid_o  = r_valid;
  assign pc_o           = r_pc;
  assign halted_o       = (r_state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_new_pc   <= RESET_PC;
      r_drop     <= 1'b0;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          if (flush_i) r_fetch_pc <= flush_pc_i;
        end
        // The address must stay stable while a request is outstanding, so a
        // flush without ack only marks the in-flight fetch for discard.
        S_FETCH: begin
          if (flush_i) begin
            if (imem.imem_ack) begin
              r_fetch_pc <= flush_pc_i;
              r_drop     <= 1'b0;
            end else begin
              r_drop   <= 1'b1;
              r_new_pc <= flush_pc_i;
            end
          end else if (imem.imem_ack) begin
            if (r_drop) begin
              r_drop     <= 1'b0;
              r_fetch_pc <= r_new_pc;
            end else begin
              r_instr <= imem.imem_data;
              r_pc    <= r_fetch_pc;
              r_valid <= 1'b1;
              r_state <= S_DELIVER;
            end
          end
        end
        S_DELIVER: begin
          if (flush_i) begin
            r_valid    <= 1'b0;
            r_fetch_pc <= flush_pc_i;
            r_state    <= S_FETCH;
          end else if (!stall_i) begin
            r_valid <= 1'b0;
            if (halt_i) begin
              r_state <= S_HALTED;
            end else begin
              r_fetch_pc <= w_next_pc;
              r_state    <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          if (flush_i) begin
            r_fetch_pc <= flush_pc_i;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed sequences, a target-address table and a randomized run vs a model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [15:0] branch_off_i;
  logic        jump_i;
  logic [25:0] jump_tgt_i;
  logic        halt_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic        halted_o;

  pc_sequencer_if #(.ADDR_W(32)) imem ();

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_off_i  (branch_off_i),
    .jump_i        (jump_i),
    .jump_tgt_i    (jump_tgt_i),
    .halt_i        (halt_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .imem          (imem),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o),
    .halted_o      (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Program-flow rule for a consumed instruction, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                             input logic [15:0] off, input logic jmp,
                                             input logic [25:0] tgt);
    logic [31:0] seq;
    seq = pc + 32'd1;
    if (jmp) return (seq & 32'hFC00_0000) | {6'b0, tgt};
    if (br)  return seq + 32'(int'($signed(off)));
    return seq;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall_i = 0; branch_i = 0; branch_off_i = 0; jump_i = 0; jump_tgt_i = 0;
    halt_i = 0; flush_i = 0; flush_pc_i = 0;
    imem.imem_ack = 0; imem.imem_data = 0;
  endtask

  task automatic fetch_ack(input logic [31:0] a);
    chk("fetch_req", imem.imem_req, 1);
    chk("fetch_addr", imem.imem_addr, a);
    imem.imem_ack = 1; imem.imem_data = mem_word(a);
    tick();
    imem.imem_ack = 0;
    chk("dlv_valid", instr_valid_o, 1);
    chk("dlv_pc", pc_o, a);
    chk("dlv_instr", instr_o, mem_word(a));
    chk("dlv_req", imem.imem_req, 0);
  endtask

  task automatic goto_pc(input logic [31:0] p);
    flush_i = 1; flush_pc_i = p;
    if (imem.imem_req) begin
      imem.imem_ack = 1; imem.imem_data = 32'hDEAD_BEEF;
    end
    tick();
    flush_i = 0; imem.imem_ack = 0;
    fetch_ack(p);
  endtask

  initial begin
    logic [31:0] m_pc;
    bit m_valid, m_halted, m_drop, exp_req;

    tv[0] = '{32'h0000_0010, 1'b1, 16'hFFFE, 1'b0, 26'h0,       32'h0000_000F};
    tv[1] = '{32'h0000_0010, 1'b1, 16'h0010, 1'b1, 26'h40,      32'h0000_0040};
    tv[2] = '{32'hFFFF_FFFF, 1'b0, 16'h0,    1'b0, 26'h0,       32'h0000_0000};
    tv[3] = '{32'h0C00_0123, 1'b0, 16'h0,    1'b1, 26'h3FFFFFF, 32'h0FFF_FFFF};
    tv[4] = '{32'h0000_0100, 1'b1, 16'h7FFF, 1'b0, 26'h0,       32'h0000_8100};
    tv[5] = '{32'h0000_0005, 1'b1, 16'h8000, 1'b0, 26'h0,       32'hFFFF_8006};
    tv[6] = '{32'h0000_0020, 1'b0, 16'h1234, 1'b0, 26'h55,      32'h0000_0021};
    tv[7] = '{32'h03FF_FFFF, 1'b0, 16'h0,    1'b1, 26'h5,       32'h0400_0005};

    idle_inputs();
    rst = 1;
    tick(); tick();
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_req", imem.imem_req, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_instr", instr_o, 0);
    rst = 0;
    tick();

    // Sequential fetch with zero-wait ack.
    for (int i = 0; i < 4; i++) begin
      fetch_ack(32'(i));
      tick();
    end

    // Stall holds the presented instruction.
    goto_pc(32'd5);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", instr_valid_o, 1);
      chk("stall_pc", pc_o, 32'd5);
      chk("stall_instr", instr_o, mem_word(32'd5));
      chk("stall_req", imem.imem_req, 0);
    end
    stall_i = 0;
    tick();
    chk("stall_rel_req", imem.imem_req, 1);
    chk("stall_rel_addr", imem.imem_addr, 32'd6);

    // Flush during a slow fetch: address held, acked data discarded.
    flush_i = 1; flush_pc_i = 32'h200;
    tick();
    flush_i = 0;
    chk("fl_addr_hold1", imem.imem_addr, 32'd6);
    chk("fl_req1", imem.imem_req, 1);
    tick();
    chk("fl_addr_hold2", imem.imem_addr, 32'd6);
    imem.imem_ack = 1; imem.imem_data = mem_word(32'd6);
    tick();
    imem.imem_ack = 0;
    chk("fl_drop_valid", instr_valid_o, 0);
    chk("fl_drop_req", imem.imem_req, 1);
    chk("fl_new_addr", imem.imem_addr, 32'h200);
    fetch_ack(32'h200);

    // Target-address table.
    for (int i = 0; i < 8; i++) begin
      goto_pc(tv[i].pc);
      branch_i = tv[i].br; branch_off_i = tv[i].off;
      jump_i = tv[i].jmp; jump_tgt_i = tv[i].tgt;
      tick();
      idle_inputs();
      chk($sformatf("tgt_req%0d", i), imem.imem_req, 1);
      chk($sformatf("tgt_addr%0d", i), imem.imem_addr, tv[i].exp);
    end

    // Halt, ignore stray acks, leave via flush.
    goto_pc(32'd7);
    halt_i = 1;
    tick();
    halt_i = 0;
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", halted_o, 1);
      chk("halt_req", imem.imem_req, 0);
      chk("halt_valid", instr_valid_o, 0);
      imem.imem_ack = 1'(i & 1); imem.imem_data = 32'hBAD0_0000;
      tick();
    end
    imem.imem_ack = 0;
    flush_i = 1; flush_pc_i = 32'h80;
    tick();
    flush_i = 0;
    chk("unhalt_flag", halted_o, 0);
    fetch_ack(32'h80);
    tick();

    // Reset beats a coincident ack.
    chk("prerst_req", imem.imem_req, 1);
    rst = 1; imem.imem_ack = 1; imem.imem_data = mem_word(32'h81);
    tick();
    rst = 0; imem.imem_ack = 0;
    chk("rst2_valid", instr_valid_o, 0);
    chk("rst2_req", imem.imem_req, 0);
    chk("rst2_pc", pc_o, 0);
    chk("rst2_instr", instr_o, 0);
    chk("rst2_halted", halted_o, 0);
    tick();
    chk("rst2_refetch_req", imem.imem_req, 1);
    chk("rst2_refetch_addr", imem.imem_addr, 0);

    // Randomized run against the program-flow model.
    m_pc = 0; m_valid = 0; m_halted = 0; m_drop = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_req = !m_valid && !m_halted;
      chk("rnd_valid", instr_valid_o, m_valid);
      chk("rnd_halted", halted_o, m_halted);
      chk("rnd_req", imem.imem_req, exp_req);
      if (m_valid) begin
        chk("rnd_pc", pc_o, m_pc);
        chk("rnd_instr", instr_o, mem_word(m_pc));
      end
      if (exp_req && !m_drop) chk("rnd_addr", imem.imem_addr, m_pc);

      stall_i      = ($urandom_range(0, 3) == 0);
      branch_i     = 1'($urandom_range(0, 1));
      jump_i       = ($urandom_range(0, 3) == 0);
      halt_i       = ($urandom_range(0, 24) == 0);
      branch_off_i = 16'($urandom);
      jump_tgt_i   = 26'($urandom);
      flush_i      = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       flush_pc_i = 32'hFFFF_FFFF;
        1:       flush_pc_i = 32'($urandom_range(0, 255));
        default: flush_pc_i = $urandom;
      endcase
      imem.imem_ack  = exp_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      imem.imem_data = imem.imem_req ? mem_word(imem.imem_addr) : $urandom;

      if (flush_i) begin
        m_drop = exp_req && !imem.imem_ack;
        m_pc = flush_pc_i; m_valid = 0; m_halted = 0;
      end else if (m_halted) begin
        m_halted = 1;
      end else if (m_valid) begin
        if (!stall_i) begin
          m_valid = 0;
          if (halt_i) m_halted = 1;
          else m_pc = model_next(m_pc, branch_i, branch_off_i, jump_i, jump_tgt_i);
        end
      end else if (imem.imem_ack) begin
        if (m_drop) m_drop = 0;
        else m_valid = 1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
